// File: rtl/memory_map_rdmux.sv
// Read-response stage: per-lane select delay line, write-bank read-data mux and a
// first-word-fall-through response FIFO, with credit-based rdready because the RAM cannot stall.
module memory_map_rdmux #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int NB_WRAGENT   = 2,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
    parameter int RD_LATENCY   = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic [NB_RDAGENT-1:0]                    rden,
    input  logic [NB_RDAGENT*SELECT_WIDTH-1:0]       rdselect,
    input  logic [NB_RDAGENT*NB_WRAGENT*DATA_WIDTH-1:0] ramdata,
    output logic [NB_RDAGENT-1:0]                    rdready,
    output logic [NB_RDAGENT-1:0]                    rdvalid,
    output logic [NB_RDAGENT*DATA_WIDTH-1:0]         rddata,
    input  logic [NB_RDAGENT-1:0]                    rdack,
    output logic [NB_RDAGENT-1:0]                    rderr
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int LAST = RD_LATENCY - 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);

    if (ADDR_WIDTH < 1 || RD_LATENCY < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("memory_map_rdmux: unsupported parameter set");
    end

    for (genvar i = 0; i < NB_RDAGENT; i++) begin : g_lane
        logic [RD_LATENCY-1:0]   r_dl_vld;
        logic [SELECT_WIDTH-1:0] r_dl_sel [RD_LATENCY];
        logic [PW-1:0]           r_cnt;
        logic [PW-1:0]           r_wptr;
        logic [PW-1:0]           r_rptr;
        logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
        logic                    r_err;
        logic                    w_ready, w_acc, w_empty, w_full, w_pop, w_push, w_bad;
        logic [SELECT_WIDTH-1:0] w_sel;
        logic [DATA_WIDTH-1:0]   w_bank;

        // Credit decode uses only the registered count; reset forces it low.
        assign w_ready = !areset && (r_cnt != DEPTH_C);
        assign w_acc   = rden[i] && w_ready;
        assign w_empty = (r_wptr == r_rptr);
        assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        assign w_pop   = !w_empty && rdack[i];
        assign w_push  = r_dl_vld[LAST] && (!w_full || w_pop);
        assign w_sel   = r_dl_sel[LAST];
        assign w_bad   = r_dl_vld[LAST] && (int'(w_sel) >= NB_WRAGENT);

        // An out-of-range select matches no bank, so the written word is zero.
        always_comb begin
            w_bank = '0;
            for (int w = 0; w < NB_WRAGENT; w++) begin
                if (int'(w_sel) == w)
                    w_bank = ramdata[DATA_WIDTH*(i*NB_WRAGENT+w) +: DATA_WIDTH];
            end
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_dl_vld <= '0;
                r_cnt    <= '0;
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_err    <= 1'b0;
            end else begin
                r_dl_vld[0] <= w_acc;
                for (int k = 1; k < RD_LATENCY; k++)
                    r_dl_vld[k] <= r_dl_vld[k-1];
                if (w_acc && !w_pop)
                    r_cnt <= r_cnt + 1'b1;
                else if (w_pop && !w_acc)
                    r_cnt <= r_cnt - 1'b1;
                if (w_push)
                    r_wptr <= r_wptr + 1'b1;
                if (w_pop)
                    r_rptr <= r_rptr + 1'b1;
                if (w_bad || (rden[i] && !w_ready))
                    r_err <= 1'b1;
            end
        end

        always_ff @(posedge aclk) begin
            r_dl_sel[0] <= rdselect[SELECT_WIDTH*i +: SELECT_WIDTH];
            for (int k = 1; k < RD_LATENCY; k++)
                r_dl_sel[k] <= r_dl_sel[k-1];
            if (w_push)
                r_mem[r_wptr[AW-1:0]] <= w_bank;
        end

        assign rdready[i] = w_ready;
        assign rdvalid[i] = !w_empty;
        assign rddata[DATA_WIDTH*i +: DATA_WIDTH] = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
        assign rderr[i]   = r_err;
    end

endmodule

// File: tb/tb_memory_map_rdmux.sv
// Bench for memory_map_rdmux: table-driven vectors, hand-written corner sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_memory_map_rdmux;
    localparam int DW = 8, NW = 3, NR = 2, SW = 2, LAT = 1, DEPTH = 4, AWID = 8;

    logic aclk = 1'b0;
    logic areset;
    logic [NR-1:0]       rden, rdack, rdready, rdvalid, rderr;
    logic [NR*SW-1:0]    rdselect;
    logic [NR*NW*DW-1:0] ramdata;
    logic [NR*DW-1:0]    rddata;
    logic [DW-1:0]       ram [NR][NW];
    int                  sel_in [NR];

    int n_chk = 0;
    int n_fail = 0;

    memory_map_rdmux #(
        .ADDR_WIDTH(AWID), .DATA_WIDTH(DW), .NB_WRAGENT(NW), .NB_RDAGENT(NR),
        .SELECT_WIDTH(SW), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .areset(areset), .rden(rden), .rdselect(rdselect),
        .ramdata(ramdata), .rdready(rdready), .rdvalid(rdvalid), .rddata(rddata),
        .rdack(rdack), .rderr(rderr)
    );

    always #5 aclk = ~aclk;

    always_comb begin
        ramdata  = '0;
        rdselect = '0;
        for (int l = 0; l < NR; l++) begin
            rdselect[SW*l +: SW] = SW'(sel_in[l]);
            for (int w = 0; w < NW; w++)
                ramdata[DW*(l*NW+w) +: DW] = ram[l][w];
        end
    end

    // Reference model: each accepted read is due at a cycle number; when due its bank
    // word (or zero for a bad select) joins the response queue.
    typedef struct { int due; int sel; } rd_t;
    rd_t infl [NR][$];
    int  fq   [NR][$];
    bit  merr [NR];
    int  cyc = 0;

    function automatic void model_reset();
        for (int l = 0; l < NR; l++) begin
            infl[l].delete();
            fq[l].delete();
            merr[l] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        if (areset) begin
            model_reset();
            return;
        end
        for (int l = 0; l < NR; l++) begin
            int  occ = infl[l].size() + fq[l].size();
            bit  rdy = (occ != DEPTH);
            if (rden[l] && !rdy) merr[l] = 1'b1;
            if (fq[l].size() > 0 && rdack[l]) void'(fq[l].pop_front());
            if (infl[l].size() > 0 && infl[l][0].due == cyc) begin
                int s = infl[l][0].sel;
                void'(infl[l].pop_front());
                if (s >= NW) begin
                    merr[l] = 1'b1;
                    fq[l].push_back(0);
                end else begin
                    fq[l].push_back(int'(ram[l][s]));
                end
            end
            if (rden[l] && rdy) infl[l].push_back('{due: cyc + LAT, sel: sel_in[l]});
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int l = 0; l < NR; l++) begin
            int occ = infl[l].size() + fq[l].size();
            chk($sformatf("%s rdready[%0d]", tag, l), 32'(rdready[l]), 32'(!areset && occ != DEPTH));
            chk($sformatf("%s rdvalid[%0d]", tag, l), 32'(rdvalid[l]), 32'(fq[l].size() > 0));
            chk($sformatf("%s rddata[%0d]", tag, l), 32'(rddata[DW*l +: DW]),
                (fq[l].size() > 0) ? 32'(fq[l][0]) : 32'd0);
            chk($sformatf("%s rderr[%0d]", tag, l), 32'(rderr[l]), 32'(merr[l]));
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge aclk);
        #1;
        cyc++;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        areset = 1'b1;
        model_reset();
        #1;
        check_all({tag, " async"});
        chk({tag, " rdready low"}, 32'(rdready), 32'd0);
        chk({tag, " rddata zero"}, 32'(rddata), 32'd0);
        tick({tag, " held"});
        areset = 1'b0;
        #1;
        check_all({tag, " release"});
        chk({tag, " rdready after release"}, 32'(rdready), 32'(2'b11));
        chk({tag, " rdvalid after release"}, 32'(rdvalid), 32'd0);
    endtask

    typedef struct {
        bit rden; int sel; logic [7:0] b0; logic [7:0] b1; bit ack;
        bit e_rdy; bit e_vld; logic [7:0] e_dat; bit e_err;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit rd, int s, logic [7:0] b0, logic [7:0] b1, bit ack,
                                bit e_rdy, bit e_vld, logic [7:0] e_dat, bit e_err);
        vec_t v;
        v.rden = rd; v.sel = s; v.b0 = b0; v.b1 = b1; v.ack = ack;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat; v.e_err = e_err;
        tbl.push_back(v);
    endfunction

    initial begin
        // Single read from bank 1, then pop.
        add(1, 1, 8'h11, 8'h22, 0, 1, 0, 8'h00, 0);
        add(0, 1, 8'h33, 8'hA5, 0, 1, 1, 8'hA5, 0);
        add(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0);
        // Eight back-to-back reads from bank 0 returning 0..7 with rdack held high.
        for (int k = 0; k <= 8; k++)
            add(k < 8, 0, (k == 0) ? 8'hEE : 8'(k - 1), 8'h77, 1, 1, k >= 1,
                (k >= 1) ? 8'(k - 1) : 8'h00, 0);
        add(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0);

        areset = 1'b1;
        rden = '0;
        rdack = '0;
        for (int l = 0; l < NR; l++) begin
            sel_in[l] = 0;
            for (int w = 0; w < NW; w++) ram[l][w] = '0;
        end
        model_reset();
        #1;
        check_all("reset");
        tick("reset");
        tick("reset");
        chk("reset rdready", 32'(rdready), 32'd0);
        chk("reset rdvalid", 32'(rdvalid), 32'd0);
        chk("reset rderr", 32'(rderr), 32'd0);
        areset = 1'b0;
        #1;
        chk("rdready after first release", 32'(rdready), 32'(2'b11));

        foreach (tbl[r]) begin
            rden[0] = tbl[r].rden;
            sel_in[0] = tbl[r].sel;
            ram[0][0] = tbl[r].b0;
            ram[0][1] = tbl[r].b1;
            ram[0][2] = 8'h5A;
            rdack[0] = tbl[r].ack;
            tick($sformatf("vec%0d", r));
            chk($sformatf("vec%0d rdready", r), 32'(rdready[0]), 32'(tbl[r].e_rdy));
            chk($sformatf("vec%0d rdvalid", r), 32'(rdvalid[0]), 32'(tbl[r].e_vld));
            chk($sformatf("vec%0d rddata", r), 32'(rddata[7:0]), 32'(tbl[r].e_dat));
            chk($sformatf("vec%0d rderr", r), 32'(rderr[0]), 32'(tbl[r].e_err));
        end

        // Backpressure: six requests against a four-deep lane with no consumer.
        rdack = '0;
        for (int p = 0; p < 6; p++) begin
            rden[0] = 1'b1;
            sel_in[0] = 2;
            ram[0][2] = 8'(8'h30 + p);
            tick($sformatf("bp%0d", p));
            if (p == 2) chk("bp rdready before full", 32'(rdready[0]), 32'd1);
            if (p == 3) chk("bp rdready at full", 32'(rdready[0]), 32'd0);
            if (p == 3) chk("bp no err yet", 32'(rderr[0]), 32'd0);
            if (p == 4) chk("bp err on dropped read", 32'(rderr[0]), 32'd1);
        end
        chk("bp head data", 32'(rddata[7:0]), 32'h31);
        rden[0] = 1'b0;
        rdack[0] = 1'b1;
        tick("bp pop");
        rdack[0] = 1'b0;
        chk("bp rdready after pop", 32'(rdready[0]), 32'd1);
        chk("bp next head", 32'(rddata[7:0]), 32'h32);
        rdack[0] = 1'b1;
        for (int p = 0; p < 4; p++) tick("bp drain");
        chk("bp drained", 32'(rdvalid[0]), 32'd0);

        // Hold three in flight/queued, then accept and pop together across pointer wrap.
        rdack[0] = 1'b0;
        rden[0] = 1'b1;
        sel_in[0] = 0;
        for (int p = 0; p < 3; p++) begin
            ram[0][0] = 8'(8'h80 + p);
            tick("fill3");
        end
        rdack[0] = 1'b1;
        for (int p = 3; p < 13; p++) begin
            ram[0][0] = 8'(8'h80 + p);
            tick($sformatf("pp%0d", p));
            chk($sformatf("pp%0d rdready", p), 32'(rdready[0]), 32'd1);
        end
        rden[0] = 1'b0;
        for (int p = 0; p < 6; p++) tick("pp drain");

        // Mid-operation reset with traffic on both lanes.
        rdack = '0;
        rden = 2'b11;
        sel_in[0] = 1;
        sel_in[1] = 2;
        for (int p = 0; p < 3; p++) begin
            ram[0][1] = 8'(8'h40 + p);
            ram[1][2] = 8'(8'h50 + p);
            tick("pre-reset");
        end
        rden = '0;
        #2;
        do_reset("midreset");

        // Bad select on lane 1, good read on lane 0 in the same cycle.
        rden = 2'b11;
        sel_in[0] = 1;
        sel_in[1] = 3;
        tick("badsel issue");
        rden = '0;
        ram[0][1] = 8'h5C;
        ram[1][0] = 8'hF1;
        ram[1][1] = 8'hF2;
        ram[1][2] = 8'hF3;
        tick("badsel land");
        chk("badsel lane1 valid", 32'(rdvalid[1]), 32'd1);
        chk("badsel lane1 data", 32'(rddata[15:8]), 32'd0);
        chk("badsel lane1 err", 32'(rderr[1]), 32'd1);
        chk("badsel lane0 data", 32'(rddata[7:0]), 32'h5C);
        chk("badsel lane0 err", 32'(rderr[0]), 32'd0);
        rdack = 2'b11;
        tick("badsel pop");
        do_reset("postbad");

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < NR; l++) begin
                rden[l] = ($urandom_range(0, 3) != 0);
                rdack[l] = ($urandom_range(0, 2) != 0);
                sel_in[l] = ($urandom_range(0, 31) == 0) ? 3 : int'($urandom_range(0, NW - 1));
                for (int w = 0; w < NW; w++) ram[l][w] = 8'($urandom);
            end
            if ($urandom_range(0, 149) == 0)
                do_reset("rand reset");
            else
                tick($sformatf("rand%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
